// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage (PC, imem handshake, IF/ID register).
// Optional IF_ALIGN_CHECK_EN: trap misaligned fetch PCs as AdEL via id_adel_o.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        id_stall_i,
`ifdef IF_ALIGN_CHECK_EN
    output logic        id_adel_o,
`endif
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_req_en;
    logic        r_drop;
    logic        w_drop_nxt;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;
    logic        r_id_valid;
    logic        w_valid_nxt;
    logic [31:0] r_id_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_id_pc;
    logic [31:0] w_idpc_nxt;
    logic        w_mis;
    logic        w_req;
    logic        w_slot_free;
    logic        w_grant;
`ifdef IF_ALIGN_CHECK_EN
    logic        r_adel;
    logic        w_adel_nxt;
    logic        r_trap;
    logic        w_trap_nxt;
`endif

`ifdef IF_ALIGN_CHECK_EN
    assign w_mis = (r_pc[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // A request only issues once out of reset and for an aligned PC
    assign w_req       = (r_state == S_REQ) & r_req_en & ~w_mis;
    assign w_grant     = w_req & imem_gnt_i;
    assign w_slot_free = ~r_id_valid | ~id_stall_i;

    assign pc_o        = r_pc;
    assign imem_addr_o = r_pc;
    assign imem_req_o  = w_req;
    assign id_valid_o  = r_id_valid;
    assign id_instr_o  = r_id_instr;
    assign id_pc_o     = r_id_pc;
`ifdef IF_ALIGN_CHECK_EN
    assign id_adel_o   = r_adel;
`endif

    // Next-state, next-PC and IF/ID update; redirect overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_hold_nxt  = r_hold;
        w_valid_nxt = r_id_valid;
        w_instr_nxt = r_id_instr;
        w_idpc_nxt  = r_id_pc;
`ifdef IF_ALIGN_CHECK_EN
        w_adel_nxt  = r_adel;
        w_trap_nxt  = r_trap;
`endif

        // Slot drains when decode consumes it and nothing refills it
        if (!id_stall_i) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
`ifdef IF_ALIGN_CHECK_EN
            w_adel_nxt  = 1'b0;
`endif
        end

        unique case (r_state)
            S_REQ: begin
                if (w_grant) begin
                    w_state_nxt = S_WAIT;
                end
`ifdef IF_ALIGN_CHECK_EN
                else if (r_req_en && w_mis && !r_trap && w_slot_free) begin
                    w_valid_nxt = 1'b1;
                    w_instr_nxt = NOP_INSTR;
                    w_idpc_nxt  = r_pc;
                    w_adel_nxt  = 1'b1;
                    w_trap_nxt  = 1'b1;
                end
`endif
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (w_slot_free) begin
                        w_valid_nxt = 1'b1;
                        w_instr_nxt = imem_rdata_i;
                        w_idpc_nxt  = r_pc;
`ifdef IF_ALIGN_CHECK_EN
                        w_adel_nxt  = 1'b0;
`endif
                        w_pc_nxt    = npc_i;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_hold_nxt  = imem_rdata_i;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall_i) begin
                    w_valid_nxt = 1'b1;
                    w_instr_nxt = r_hold;
                    w_idpc_nxt  = r_pc;
`ifdef IF_ALIGN_CHECK_EN
                    w_adel_nxt  = 1'b0;
`endif
                    w_pc_nxt    = npc_i;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        if (redirect_i) begin
            w_pc_nxt    = redirect_pc_i;
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
`ifdef IF_ALIGN_CHECK_EN
            w_adel_nxt  = 1'b0;
            w_trap_nxt  = 1'b0;
`endif
            // An outstanding granted fetch must still be absorbed
            if (r_state == S_WAIT && !imem_rvalid_i) begin
                w_drop_nxt  = 1'b1;
                w_state_nxt = S_WAIT;
            end else if (w_grant) begin
                w_drop_nxt  = 1'b1;
                w_state_nxt = S_WAIT;
            end else begin
                w_drop_nxt  = 1'b0;
                w_state_nxt = S_REQ;
            end
        end
    end

    // FSM, PC and drop/hold bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_en <= 1'b0;
            r_drop   <= 1'b0;
            r_hold   <= NOP_INSTR;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_req_en <= 1'b1;
            r_drop   <= w_drop_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= 32'h0000_0000;
        end else begin
            r_id_valid <= w_valid_nxt;
            r_id_instr <= w_instr_nxt;
            r_id_pc    <= w_idpc_nxt;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    // Address-error flag travels with the IF/ID slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adel <= 1'b0;
            r_trap <= 1'b0;
        end else begin
            r_adel <= w_adel_nxt;
            r_trap <= w_trap_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table, reset/align sequences and a
// randomized run checked against a fetch-stream scoreboard.
module tb_if_stage;

    localparam logic [31:0] B   = 32'hBFC0_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] T1  = 32'h8000_0100;
    localparam logic [31:0] TW  = 32'hFFFF_FFFC;
    localparam logic [31:0] LI  = 32'h2408_0001;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_o;
    logic [31:0] npc_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
`ifdef IF_ALIGN_CHECK_EN
    logic        id_adel_o;
`endif

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_o          (pc_o),
        .npc_i         (npc_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_stall_i    (id_stall_i),
`ifdef IF_ALIGN_CHECK_EN
        .id_adel_o     (id_adel_o),
`endif
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o)
    );

    assign npc_i = pc_o + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_idpc;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic st, input logic re, input logic [31:0] rp);
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        id_stall_i    = st;
        redirect_i    = re;
        redirect_pc_i = rp;
    endtask

    // scoreboard / memory model state
    logic [31:0] exp_pc;
    logic [31:0] paddr;
    logic [31:0] rpc;
    logic [31:0] q_instr;
    logic [31:0] q_idpc;
    logic        q_valid;
    logic        pend;
    logic        p_stall;
    logic        p_redir;
    logic [31:0] p_rpc;
    logic        g;
    logic        rv;
    logic        st;
    logic        re;
    logic [31:0] rd;
    int          cnt;
    int          ndel;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        tbl.push_back('{1, 0, 0,  0, 0, 0,  1, B,      0, 0,   0});
        tbl.push_back('{0, 1, 32'h1000_0000, 0, 0, 0,  0, B, 0, 0, 0});
        tbl.push_back('{1, 0, 0,  0, 0, 0,  1, B+4,    1, 32'h1000_0000, B});
        tbl.push_back('{0, 1, 32'h1000_0001, 0, 0, 0,  0, B+4, 0, 0, B});
        tbl.push_back('{1, 0, 0,  0, 0, 0,  1, B+8,    1, 32'h1000_0001, B+4});
        tbl.push_back('{0, 1, 32'h1000_0002, 0, 0, 0,  0, B+8, 0, 0, B+4});
        tbl.push_back('{1, 0, 0,  1, 0, 0,  1, B+12,   1, 32'h1000_0002, B+8});
        tbl.push_back('{0, 1, LI, 1, 0, 0,  0, B+12,   1, 32'h1000_0002, B+8});
        tbl.push_back('{0, 0, 0,  1, 0, 0,  0, B+12,   1, 32'h1000_0002, B+8});
        tbl.push_back('{0, 0, 0,  1, 0, 0,  0, B+12,   1, 32'h1000_0002, B+8});
        tbl.push_back('{0, 0, 0,  1, 0, 0,  0, B+12,   1, 32'h1000_0002, B+8});
        tbl.push_back('{0, 0, 0,  0, 0, 0,  0, B+12,   1, 32'h1000_0002, B+8});
        tbl.push_back('{1, 0, 0,  0, 0, 0,  1, B+16,   1, LI, B+12});
        tbl.push_back('{0, 0, 0,  0, 1, T1, 0, B+16,   0, 0,  B+12});
        tbl.push_back('{0, 0, 0,  0, 0, 0,  0, T1,     0, 0,  B+12});
        tbl.push_back('{0, 0, 0,  0, 0, 0,  0, T1,     0, 0,  B+12});
        tbl.push_back('{0, 1, DB, 0, 0, 0,  0, T1,     0, 0,  B+12});
        tbl.push_back('{1, 0, 0,  0, 0, 0,  1, T1,     0, 0,  B+12});
        tbl.push_back('{0, 1, 32'h1000_0003, 0, 0, 0,  0, T1, 0, 0, B+12});
        tbl.push_back('{1, 0, 0,  1, 0, 0,  1, T1+4,   1, 32'h1000_0003, T1});
        tbl.push_back('{0, 1, 32'h1000_0004, 1, 1, TW, 0, T1+4, 1, 32'h1000_0003, T1});
        tbl.push_back('{1, 0, 0,  0, 0, 0,  1, TW,     0, 0,  T1});
        tbl.push_back('{0, 1, 32'h1000_0005, 0, 0, 0,  0, TW, 0, 0, T1});
        tbl.push_back('{0, 0, 0,  0, 0, 0,  1, 0,      1, 32'h1000_0005, TW});
        tbl.push_back('{1, 0, 0,  0, 1, 32'h40, 1, 0,  0, 0,  TW});
        tbl.push_back('{0, 1, 32'hAAAA_AAAA, 0, 0, 0,  0, 32'h40, 0, 0, TW});
        tbl.push_back('{1, 0, 0,  0, 0, 0,  1, 32'h40, 0, 0,  TW});
        tbl.push_back('{0, 1, 32'h1000_0006, 0, 0, 0,  0, 32'h40, 0, 0, TW});
        tbl.push_back('{1, 0, 0,  1, 0, 0,  1, 32'h44, 1, 32'h1000_0006, 32'h40});

        // reset values
        @(negedge clk);
        chk("rst_pc", pc_o, B);
        chk("rst_req", {31'd0, imem_req_o}, 0);
        chk("rst_valid", {31'd0, id_valid_o}, 0);
        chk("rst_instr", id_instr_o, NOP);
        chk("rst_idpc", id_pc_o, 0);
        rst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            chk($sformatf("row%0d_req", i), {31'd0, imem_req_o},
                {31'd0, tbl[i].e_req});
            chk($sformatf("row%0d_pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("row%0d_valid", i), {31'd0, id_valid_o},
                {31'd0, tbl[i].e_valid});
            chk($sformatf("row%0d_instr", i), id_instr_o, tbl[i].e_instr);
            chk($sformatf("row%0d_idpc", i), id_pc_o, tbl[i].e_idpc);
            drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].stall,
                  tbl[i].redir, tbl[i].rpc);
        end

        // async reset in S_WAIT with a valid slot
        @(negedge clk);
        chk("prerst_valid", {31'd0, id_valid_o}, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc_o, B);
        chk("arst_valid", {31'd0, id_valid_o}, 0);
        chk("arst_instr", id_instr_o, NOP);
        chk("arst_idpc", id_pc_o, 0);
        chk("arst_req", {31'd0, imem_req_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, DB, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        chk("stale_valid", {31'd0, id_valid_o}, 0);
        chk("stale_pc", pc_o, B);
        chk("stale_req", {31'd0, imem_req_o}, 1);

        // randomized run against a fetch-stream scoreboard
        exp_pc  = B;
        pend    = 1'b0;
        cnt     = 0;
        paddr   = 0;
        p_stall = 1'b0;
        p_redir = 1'b0;
        p_rpc   = 0;
        q_valid = 1'b0;
        q_instr = 0;
        q_idpc  = 0;
        ndel    = 0;
        for (int c = 0; c < 3020; c++) begin
            @(negedge clk);
            chk("addr_eq_pc", imem_addr_o, pc_o);
            if (p_redir) begin
                chk("rnd_flush", {31'd0, id_valid_o}, 0);
                exp_pc = p_rpc;
            end else if (p_stall && q_valid) begin
                chk("rnd_hold_valid", {31'd0, id_valid_o}, 1);
                chk("rnd_hold_instr", id_instr_o, q_instr);
                chk("rnd_hold_pc", id_pc_o, q_idpc);
            end else if (id_valid_o) begin
                chk("rnd_pc_seq", id_pc_o, exp_pc);
                chk("rnd_instr", id_instr_o, mem_word(id_pc_o));
                exp_pc = id_pc_o + 32'd4;
                ndel++;
            end
            if (!id_valid_o) chk("rnd_nop", id_instr_o, NOP);
            q_valid = id_valid_o;
            q_instr = id_instr_o;
            q_idpc  = id_pc_o;

            if (imem_req_o) chk("one_outstanding", {31'd0, pend}, 0);
            rv = 1'b0;
            rd = 0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    rv   = 1'b1;
                    rd   = mem_word(paddr);
                    pend = 1'b0;
                end
            end
            g = 1'b0;
            if (imem_req_o && !pend && ($urandom % 3 != 0)) begin
                g     = 1'b1;
                pend  = 1'b1;
                cnt   = $urandom_range(1, 3);
                paddr = imem_addr_o;
            end
            st  = (c < 3000) && ($urandom % 3 == 0);
            re  = (c < 3000) && ($urandom % 16 == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            drive(g, rv, rd, st, re, rpc);
            p_stall = st;
            p_redir = re;
            p_rpc   = rpc;
        end
        chk("rnd_progress", {31'd0, ndel >= 100}, 1);

`ifdef IF_ALIGN_CHECK_EN
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h8000_0102);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        chk("al_req0", {31'd0, imem_req_o}, 0);
        chk("al_pc", pc_o, 32'h8000_0102);
        @(negedge clk);
        chk("al_req1", {31'd0, imem_req_o}, 0);
        chk("al_valid", {31'd0, id_valid_o}, 1);
        chk("al_adel", {31'd0, id_adel_o}, 1);
        chk("al_idpc", id_pc_o, 32'h8000_0102);
        chk("al_instr", id_instr_o, NOP);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the architectural PC and drives it to the next-PC computation block; consumes the next-PC value that block returns.
- Runs a request/response handshake with instruction memory.
- Delivers the fetched instruction plus its PC to the decode stage through an IF/ID register with valid/stall/flush control.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction value driven on id_instr_o when the IF/ID slot is invalid.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_o  output  32  current fetch PC; drives the next-PC block's pc input.
- npc_i  input  32  next PC returned by the next-PC block for pc_o.
- redirect_i  input  1  taken branch/jump resolved downstream; discard the in-flight fetch.
- redirect_pc_i  input  32  target PC when redirect_i=1.
- imem_req_o  output  1  instruction-memory request valid.
- imem_addr_o  output  32  request address (equals pc_o).
- imem_gnt_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  32  instruction word.
- id_stall_i  input  1  decode cannot accept a new instruction.
- id_valid_o  output  1  IF/ID slot holds a valid instruction.
- id_instr_o  output  32  IF/ID instruction.
- id_pc_o  output  32  PC of id_instr_o.

Behaviour:
- Reset (async assert, sync release):
  - pc_o=RESET_PC.
  - FSM=S_REQ.
  - id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_o=0.
  - imem_req_o=0 during reset; asserts from the first clock after release.
- FSM states: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - imem_req_o=1, imem_addr_o=pc_o.
  - On imem_gnt_i → S_WAIT.
- S_WAIT:
  - imem_req_o=0. Memory returns exactly one response per grant, at least 1 cycle after the grant.
  - On imem_rvalid_i:
    - If IF/ID is free (id_valid_o=0 or id_stall_i=0): load IF/ID with {rdata, pc_o}, set id_valid_o=1, pc_o<=npc_i, → S_REQ.
    - Otherwise: latch rdata into an internal hold buffer → S_HOLD.
- S_HOLD:
  - When id_stall_i falls: move the buffer into IF/ID, pc_o<=npc_i, → S_REQ.
- IF/ID when the slot is not refilled:
  - If id_stall_i=0 and the slot is not refilled: id_valid_o<=0, id_instr_o<=NOP_INSTR.
  - If id_stall_i=1: IF/ID holds all fields unchanged.
- Redirect (highest priority, any state):
  - pc_o<=redirect_pc_i.
  - id_valid_o<=0, id_instr_o<=NOP_INSTR.
  - Hold buffer discarded.
  - Redirect overrides id_stall_i.
  - If a granted response is still outstanding (S_WAIT without rvalid this cycle), set a drop flag. The next rvalid is then discarded without touching the PC or IF/ID; the drop flag clears; FSM → S_REQ.
  - Otherwise → S_REQ.
  - A redirect in the same cycle as rvalid discards that data.
  - Redirect in S_REQ while gnt=1: the granted request is treated as outstanding (drop flag set) and the FSM stays in S_WAIT for it.
- Back-to-back: throughput is one instruction per 2 cycles minimum (req+gnt cycle, then rvalid cycle). The request for the next PC issues the cycle after rvalid.
- Arithmetic: the PC is 32-bit; this block adds nothing to it. Next-PC wrap is the upstream block's concern, so 32'hFFFF_FFFC→0 passes through unchanged.
- Timing: imem_addr_o and pc_o are registered outputs with no combinational path from inputs. id_* are registered.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Enabled:
  - Adds output id_adel_o (1 bit), registered alongside IF/ID.
  - When pc_o[1:0]!=0 in S_REQ, no memory request issues; IF/ID loads id_valid_o=1, id_instr_o=NOP_INSTR, id_pc_o=pc_o, id_adel_o=1.
  - The FSM then waits in S_REQ until redirect_i. Stall and hold rules for the IF/ID slot are unchanged.
- Disabled: no port; misaligned PCs are fetched normally.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after grant, npc_i=pc_o+4 → id_pc_o sequence BFC00000, BFC00004, BFC00008; id_valid_o=1 every second cycle.
- id_stall_i=1 for 5 cycles while rdata=32'h2408_0001 arrives → IF/ID unchanged during stall; hold buffer delivers 24080001 on the first cycle after the stall drops; exactly one request per instruction.
- Redirect to 32'h8000_0100 while in S_WAIT, rvalid arrives 3 cycles later with 32'hDEADBEEF → data dropped, id_valid_o stays 0, next request address 80000100.
- Redirect in the same cycle as rvalid and stall → IF/ID flushed (id_valid_o=0, id_instr_o=0), pc_o=redirect_pc_i next cycle.
- rst_n asserted mid-S_WAIT → pc_o=BFC00000 and id_valid_o=0 immediately without a clock edge; a stale rvalid after release is ignored because no request has been granted.
- With IF_ALIGN_CHECK_EN, redirect to 32'h8000_0102 → imem_req_o stays 0, id_adel_o=1, id_pc_o=80000102.
